// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - microstep T-state sequencer with commit gating, wait states, halt/step control
//
// Generates the T-state that indexes decode and a commit enable that gates all
// bus register writes. Handles memory wait states with a timeout, halt/run/
// single-step control and counts retired instructions.
//
// Optional feature macro: IRQ_EN (adds i_irq, i_ie, o_irq_take).
//
// Ports:
//   i_clk        system clock, all state on rising edge
//   i_reset      synchronous active-high reset
//   i_rt         current microstep is the last of the instruction
//   i_mem_req    current microstep accesses memory
//   i_mem_ready  memory completes the access this cycle
//   i_halt_req   stop at the next instruction boundary (level)
//   i_run        pulse: leave HALT, free-run
//   i_step       pulse: leave HALT, execute one instruction, re-halt
//   i_err_clr    pulse: leave ERR to HALT
//   i_irq/i_ie   interrupt request / enable (IRQ_EN only)
//   o_t          current T-state
//   o_commit     current microstep completes; register writes enabled
//   o_stall      waiting for memory
//   o_halted     in HALT
//   o_bus_err    in ERR (wait timeout)
//   o_boundary   last step of an instruction commits this cycle
//   o_retired    instructions completed since reset
//   o_irq_take   T0 of the instruction following an accepted interrupt (IRQ_EN only)
module cpu_sequencer #(
    parameter int TBITS    = 3,
    parameter int TMAX     = 7,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rt,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    input  logic             i_halt_req,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_err_clr,
`ifdef IRQ_EN
    input  logic             i_irq,
    input  logic             i_ie,
    output logic             o_irq_take,
`endif
    output logic [TBITS-1:0] o_t,
    output logic             o_commit,
    output logic             o_stall,
    output logic             o_halted,
    output logic             o_bus_err,
    output logic             o_boundary,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [TBITS-1:0] L_TMAX      = TBITS'(TMAX);
    // The transition to ERR happens at the edge ending the WAIT_MAX-th stall cycle.
    localparam logic [7:0]       L_WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t           r_state, w_state_nx;
    logic [TBITS-1:0] r_t, w_t_nx;
    logic [7:0]       r_wait, w_wait_nx;
    logic [CNT_W-1:0] r_retired, w_retired_nx;
    logic             r_armed, w_armed_nx;

    logic w_in_run, w_pending, w_stall, w_commit, w_last, w_boundary, w_stop;

    assign w_in_run   = (r_state == S_RUN);
    assign w_pending  = i_mem_req && !i_mem_ready;
    assign w_stall    = w_in_run && w_pending;
    assign w_commit   = w_in_run && !w_pending;
    // rt only matters when the step actually commits; while stalled it is ignored.
    assign w_last     = i_rt || (r_t == L_TMAX);
    assign w_boundary = w_commit && w_last;
    assign w_stop     = i_halt_req || r_armed;

    always_comb begin
        w_state_nx   = r_state;
        w_t_nx       = r_t;
        w_wait_nx    = r_wait;
        w_retired_nx = r_retired;
        w_armed_nx   = r_armed;
        case (r_state)
            S_RUN: begin
                if (w_stall) begin
                    w_wait_nx = r_wait + 8'd1;
                    if (r_wait == L_WAIT_LAST) begin
                        w_state_nx = S_ERR;
                    end
                end else begin
                    w_wait_nx = 8'd0;
                    if (w_last) begin
                        w_t_nx       = '0;
                        w_retired_nx = r_retired + CNT_W'(1);
                        if (w_stop) begin
                            w_state_nx = S_HALT;
                            w_armed_nx = 1'b0;
                        end
                    end else begin
                        w_t_nx = r_t + TBITS'(1);
                    end
                end
            end
            S_HALT: begin
                w_t_nx = '0;
                if (i_step) begin
                    w_state_nx = S_RUN;
                    w_armed_nx = 1'b1;
                end else if (i_run) begin
                    w_state_nx = S_RUN;
                end
            end
            S_ERR: begin
                if (i_err_clr) begin
                    w_state_nx = S_HALT;
                    w_t_nx     = '0;
                    w_wait_nx  = 8'd0;
                    w_armed_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_HALT;
                w_t_nx     = '0;
                w_wait_nx  = 8'd0;
                w_armed_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_HALT;
            r_t       <= '0;
            r_wait    <= 8'd0;
            r_retired <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_t       <= w_t_nx;
            r_wait    <= w_wait_nx;
            r_retired <= w_retired_nx;
            r_armed   <= w_armed_nx;
        end
    end

`ifdef IRQ_EN
    // Interrupt is accepted only at a boundary that keeps running; a halt
    // at the same boundary defers it until the first boundary after resume.
    logic r_irq_take;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_take <= 1'b0;
        end else begin
            r_irq_take <= w_boundary && !w_stop && i_irq && i_ie;
        end
    end
    assign o_irq_take = r_irq_take;
`endif

    assign o_t        = r_t;
    assign o_commit   = w_commit;
    assign o_stall    = w_stall;
    assign o_halted   = (r_state == S_HALT);
    assign o_bus_err  = (r_state == S_ERR);
    assign o_boundary = w_boundary;
    assign o_retired  = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
    localparam int TBITS = 3, TMAX = 7, WAIT_MAX = 15, CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, rt = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic halt_req = 1'b0, run = 1'b0, step = 1'b0, err_clr = 1'b0;
    logic [TBITS-1:0] t;
    logic commit, stall, halted, bus_err, boundary;
    logic [CNT_W-1:0] retired;
`ifdef IRQ_EN
    logic irq = 1'b0, ie = 1'b0, irq_take;
`endif

    cpu_sequencer #(.TBITS(TBITS), .TMAX(TMAX), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset(reset), .i_rt(rt), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
        .i_halt_req(halt_req), .i_run(run), .i_step(step), .i_err_clr(err_clr),
`ifdef IRQ_EN
        .i_irq(irq), .i_ie(ie), .o_irq_take(irq_take),
`endif
        .o_t(t), .o_commit(commit), .o_stall(stall), .o_halted(halted),
        .o_bus_err(bus_err), .o_boundary(boundary), .o_retired(retired)
    );

    typedef struct {
        string tag;
        int    t;
        bit    c, s, h, e, b, it;
        int    r;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int ret = 0;

    task automatic chk(input string tag, input string f, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, f, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int et, input bit c, input bit s, input bit h,
                        input bit e, input bit b, input bit it);
        exp_t x;
        x.tag = tag; x.t = et; x.c = c; x.s = s; x.h = h; x.e = e; x.b = b; x.it = it; x.r = ret;
        sb.push_back(x);
    endtask

    task automatic tick();
        exp_t x;
        @(negedge clk);
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, "t",        32'(t),        32'(x.t));
            chk(x.tag, "commit",   32'(commit),   32'(x.c));
            chk(x.tag, "stall",    32'(stall),    32'(x.s));
            chk(x.tag, "halted",   32'(halted),   32'(x.h));
            chk(x.tag, "bus_err",  32'(bus_err),  32'(x.e));
            chk(x.tag, "boundary", 32'(boundary), 32'(x.b));
            chk(x.tag, "retired",  32'(retired),  32'(x.r));
`ifdef IRQ_EN
            chk(x.tag, "irq_take", 32'(irq_take), 32'(x.it));
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push("reset", 0, 0, 0, 1, 0, 0, 0); tick();

        // rt every 4th committed step
        run = 1'b1; push("run_pulse", 0, 0, 0, 1, 0, 0, 0); tick(); run = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rt = (i % 4 == 3);
            push("rt4", i % 4, 1, 0, 0, 0, (i % 4 == 3), 0); tick();
            if (i % 4 == 3) ret++;
        end
        rt = 1'b0;

        // no rt: wrap at TMAX
        for (int j = 0; j < 16; j++) begin
            push("wrap", j % 8, 1, 0, 0, 0, (j % 8 == 7), 0); tick();
            if (j % 8 == 7) ret++;
        end

        // three wait states at t=1, rt during stall must be ignored
        push("pre_stall", 0, 1, 0, 0, 0, 0, 0); tick();
        mem_req = 1'b1; mem_ready = 1'b0; rt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push("stall3", 1, 0, 1, 0, 0, 0, 0); tick();
        end
        mem_ready = 1'b1; rt = 1'b0;
        push("stall_done", 1, 1, 0, 0, 0, 0, 0); tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        push("after_stall", 2, 1, 0, 0, 0, 0, 0); tick();
        rt = 1'b1;
        push("end_instr", 3, 1, 0, 0, 0, 1, 0); tick(); ret++;
        rt = 1'b0;

        // timeout: WAIT_MAX stall cycles at t=1
        push("pre_to", 0, 1, 0, 0, 0, 0, 0); tick();
        mem_req = 1'b1;
        for (int k = 0; k < WAIT_MAX; k++) begin
            push("to_stall", 1, 0, 1, 0, 0, 0, 0); tick();
        end
        run = 1'b1;
        push("err", 1, 0, 0, 0, 1, 0, 0); tick();
        run = 1'b0; err_clr = 1'b1;
        push("err_run_ign", 1, 0, 0, 0, 1, 0, 0); tick();
        err_clr = 1'b0; mem_req = 1'b0;
        push("err_clr", 0, 0, 0, 1, 0, 0, 0); tick();

        // ready on cycle WAIT_MAX: commit wins
        run = 1'b1; push("run2", 0, 0, 0, 1, 0, 0, 0); tick(); run = 1'b0;
        mem_req = 1'b1;
        for (int k = 0; k < WAIT_MAX - 1; k++) begin
            push("late_stall", 0, 0, 1, 0, 0, 0, 0); tick();
        end
        mem_ready = 1'b1;
        push("late_commit", 0, 1, 0, 0, 0, 0, 0); tick();
        mem_req = 1'b0; mem_ready = 1'b0; rt = 1'b1; halt_req = 1'b1;
        push("halt_bnd", 1, 1, 0, 0, 0, 1, 0); tick(); ret++;
        rt = 1'b0;
        push("halt_held", 0, 0, 0, 1, 0, 0, 0); tick();
        halt_req = 1'b0;

        // single step
        step = 1'b1; push("step_pulse", 0, 0, 0, 1, 0, 0, 0); tick(); step = 1'b0;
        push("step_t0", 0, 1, 0, 0, 0, 0, 0); tick();
        push("step_t1", 1, 1, 0, 0, 0, 0, 0); tick();
        rt = 1'b1;
        push("step_t2", 2, 1, 0, 0, 0, 1, 0); tick(); ret++;
        rt = 1'b0;
        push("step_rehalt", 0, 0, 0, 1, 0, 0, 0); tick();
        push("step_stay", 0, 0, 0, 1, 0, 0, 0); tick();

        // run and step together: step wins
        run = 1'b1; step = 1'b1;
        push("rs_pulse", 0, 0, 0, 1, 0, 0, 0); tick();
        run = 1'b0; step = 1'b0;
        push("rs_t0", 0, 1, 0, 0, 0, 0, 0); tick();
        rt = 1'b1;
        push("rs_t1", 1, 1, 0, 0, 0, 1, 0); tick(); ret++;
        rt = 1'b0;
        push("rs_rehalt", 0, 0, 0, 1, 0, 0, 0); tick();

`ifdef IRQ_EN
        run = 1'b1; push("irq_run", 0, 0, 0, 1, 0, 0, 0); tick(); run = 1'b0;
        irq = 1'b1; ie = 1'b1;
        push("irq_t0", 0, 1, 0, 0, 0, 0, 0); tick();
        rt = 1'b1;
        push("irq_bnd", 1, 1, 0, 0, 0, 1, 0); tick(); ret++;
        rt = 1'b0;
        push("irq_take", 0, 1, 0, 0, 0, 0, 1); tick();
        push("irq_once", 1, 1, 0, 0, 0, 0, 0); tick();
        rt = 1'b1; halt_req = 1'b1;
        push("irq_halt_bnd", 2, 1, 0, 0, 0, 1, 0); tick(); ret++;
        rt = 1'b0; halt_req = 1'b0;
        push("irq_halted", 0, 0, 0, 1, 0, 0, 0); tick();
        run = 1'b1;
        push("irq_resume", 0, 0, 0, 1, 0, 0, 0); tick(); run = 1'b0;
        rt = 1'b1;
        push("irq_bnd2", 0, 1, 0, 0, 0, 1, 0); tick(); ret++;
        rt = 1'b0; irq = 1'b0;
        push("irq_take2", 0, 1, 0, 0, 0, 0, 1); tick();
        rt = 1'b1; halt_req = 1'b1;
        push("irq_off_bnd", 1, 1, 0, 0, 0, 1, 0); tick(); ret++;
        rt = 1'b0; halt_req = 1'b0;
        push("irq_off_halt", 0, 0, 0, 1, 0, 0, 0); tick();
`endif

        // reset in the middle of a stall
        run = 1'b1; push("rst_run", 0, 0, 0, 1, 0, 0, 0); tick(); run = 1'b0;
        mem_req = 1'b1;
        push("rst_stall0", 0, 0, 1, 0, 0, 0, 0); tick();
        push("rst_stall1", 0, 0, 1, 0, 0, 0, 0); tick();
        reset = 1'b1;
        push("rst_stall2", 0, 0, 1, 0, 0, 0, 0); tick();
        reset = 1'b0; mem_req = 1'b0; ret = 0;
        push("rst_mid", 0, 0, 0, 1, 0, 0, 0); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Parametrised successor to the fixed 3-bit T-state counter: generates the microstep T-state that indexes decode, and a commit enable that gates every register write on the bus.
- Adds memory wait-state handling with timeout, halt/run/single-step control and a retired-instruction counter.
- Sits between decode/control and all bus-attached registers; the PC, IR, X, Y and FR write strobes are ANDed with commit.

Parameters:
- TBITS, 3, width of T-state output.
- TMAX, 7, last legal T-state; must be < 2^TBITS. T auto-wraps to 0 after TMAX.
- WAIT_MAX, 15, maximum consecutive stall cycles before bus error; 1..255.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- rt  in  1  microcode reset-T: current step is the last of the instruction.
- mem_req  in  1  current microstep accesses memory (MI/RO/DI asserted).
- mem_ready  in  1  memory completes the access this cycle.
- halt_req  in  1  stop at the next instruction boundary (level).
- run  in  1  pulse: leave HALT, resume free-running.
- step  in  1  pulse: leave HALT, execute exactly one instruction, re-halt.
- err_clr  in  1  pulse: leave ERR to HALT.
- t  out  TBITS  current T-state.
- commit  out  1  current microstep completes this cycle; register writes enabled.
- stall  out  1  waiting for mem_ready.
- halted  out  1  in HALT.
- bus_err  out  1  in ERR (wait timeout).
- boundary  out  1  commit && (rt || t==TMAX): last step of an instruction.
- retired  out  CNT_W  instructions completed since reset.

Behaviour:
- States: RUN, HALT, ERR. Stall is a RUN sub-condition, not a separate state.
- Reset: state=HALT; t=0; wait counter=0; retired=0; commit=0, stall=0, halted=1, bus_err=0, boundary=0. Reset overrides all inputs, including mid-stall.
- RUN: commit = !(mem_req && !mem_ready); stall = mem_req && !mem_ready. commit and stall are combinational from state/inputs.
- On commit: if rt or t==TMAX, then t<=0 and retired<=retired+1, wrapping modulo 2^CNT_W; otherwise t<=t+1. The wait counter is cleared on commit.
- On stall: t holds and the wait counter increments. When the counter reaches WAIT_MAX with stall still asserted, go to ERR next cycle; t holds its value for debug.
- mem_ready arriving on cycle WAIT_MAX: commit wins and there is no error.
- Boundary actions, evaluated at the edge where boundary=1:
  - halt_req=1, or single-step armed: go to HALT after t<=0. The instruction completes and is counted.
- HALT: commit=0, t holds at 0, halted=1.
  - run: go to RUN next cycle.
  - step: go to RUN with single-step armed.
  - run and step together: step wins.
  - halt_req ignored in HALT.
- ERR: commit=0, bus_err=1; counters hold.
  - err_clr: go to HALT and set t<=0, retired unchanged.
  - run/step ignored in ERR.
- Single-step arm flag: cleared when HALT is entered, and on reset.
- rt asserted while stalled has no effect until commit.

Optional Feature:
IRQ_EN. Adds ports irq (in, 1, level), ie (in, 1, interrupt enable) and irq_take (out, 1).
- With IRQ_EN defined: at a boundary in RUN with irq && ie, irq_take registers high for exactly the following cycle. That cycle is T0 of the next instruction, in which the control path substitutes vector fetch for normal fetch.
- If halt_req coincides, halt wins and irq is re-sampled at the first boundary after resume.
- irq_take is 0 in HALT/ERR and after reset.
- Without IRQ_EN: the ports do not exist and behaviour is identical to the above with irq_take absent.

Test Plan:
- Reset then run, rt asserted every 4th committed cycle, no mem_req -> t sequence 0,1,2,3,0,...; boundary every 4 cycles; retired=3 after 12 cycles.
- rt never asserted, TMAX=7 -> t counts 0..7 then wraps to 0; boundary at t=7; retired increments once per 8 cycles.
- mem_req at t=1 with mem_ready low for 3 cycles, then high -> stall=1 for 3 cycles, commit=0, t held at 1; commit on 4th cycle; t=2 next.
- mem_ready held low for WAIT_MAX=15 cycles -> ERR entered, bus_err=1, t frozen; err_clr -> halted=1, t=0, retired unchanged; mem_ready on cycle 15 in a separate run gives no error.
- From HALT pulse step, rt at t=2 -> exactly one instruction (t 0,1,2), retired +1, halted=1 again; run and step in the same cycle -> single-step behaviour.
- IRQ_EN: irq=ie=1 asserted mid-instruction -> irq_take high exactly one cycle at the T0 after the boundary; with halt_req also high -> HALT, no irq_take until resume.
